panel_scan: RTL and testbench

- Time-multiplexed scanner for a common-segment 7-segment panel of DIGITS hex digits.
- Upstream of the hex-to-segment decoder: feeds it one nibble at a time through nibble_o.
- Downstream of the decoder: takes its 8-bit segment pattern on seg_i, inserts the decimal point, and drives the panel.
- Adds tear-free value loading, leading-zero blanking, inter-digit ghost guard and PWM brightness.

---
 rtl/panel_scan.sv | 119 +++++++++++
 tb/tb_panel_scan.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/panel_scan.sv
// Time-multiplexed 7-segment panel scanner: buffered value loading, leading-zero
// blanking, inter-digit guard interval and PWM brightness around an external decoder.
module panel_scan #(
   parameter int DIGITS    = 8,
   parameter int SLOT_BITS = 16,
   parameter int GUARD     = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [4*DIGITS-1:0]   value_i,
   input  logic [DIGITS-1:0]     dp_i,
   input  logic                  load_i,
   output logic                  ack_o,
   input  logic                  blank_lz_i,
   input  logic [3:0]            bright_i,
   output logic [3:0]            nibble_o,
   input  logic [7:0]            seg_i,
   output logic [7:0]            seg_o,
   output logic [DIGITS-1:0]     an_o
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [SLOT_BITS-1:0]  cnt;
   logic [IDX_W-1:0]      idx;
   logic [4*DIGITS-1:0]   disp_val;
   logic [DIGITS-1:0]     disp_dp;
   logic [4*DIGITS-1:0]   pend_val;
   logic [DIGITS-1:0]     pend_dp;
   logic                  pend;

   logic                  tick;
   logic                  frame;
   logic                  hi_zero;
   logic [DIGITS-1:0]     blank_vec;
   logic                  lit;

   assign tick  = (cnt == {SLOT_BITS{1'b1}});
   assign frame = tick && (idx == IDX_W'(DIGITS - 1));

   // A digit is blanked when it and every more significant digit are zero and it has no dp.
   always_comb begin
      blank_vec = {DIGITS{1'b0}};
      hi_zero   = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         hi_zero      = hi_zero & (disp_val[4*k +: 4] == 4'd0);
         blank_vec[k] = blank_lz_i & hi_zero & ~disp_dp[k];
      end
   end

   // GUARD >= 1 also guarantees nibble_o (and so seg_i) already reflects the current idx.
   assign lit = (cnt >= SLOT_BITS'(GUARD)) &&
                (cnt[SLOT_BITS-1 -: 4] <= bright_i) &&
                !blank_vec[idx];

   // Slot counter and digit index.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt <= {SLOT_BITS{1'b0}};
         idx <= {IDX_W{1'b0}};
      end else begin
         cnt <= cnt + SLOT_BITS'(1);
         if (tick) begin
            if (idx == IDX_W'(DIGITS - 1)) begin
               idx <= {IDX_W{1'b0}};
            end else begin
               idx <= idx + IDX_W'(1);
            end
         end
      end
   end

   // Pending buffer capture and frame-aligned commit to the displayed value.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         disp_val <= {(4*DIGITS){1'b0}};
         disp_dp  <= {DIGITS{1'b0}};
         pend_val <= {(4*DIGITS){1'b0}};
         pend_dp  <= {DIGITS{1'b0}};
         pend     <= 1'b0;
         ack_o    <= 1'b0;
      end else begin
         if (frame && pend) begin
            disp_val <= pend_val;
            disp_dp  <= pend_dp;
            ack_o    <= 1'b1;
         end else begin
            ack_o    <= 1'b0;
         end
         // A capture coincident with a commit stays pending for the next frame.
         if (load_i) begin
            pend_val <= value_i;
            pend_dp  <= dp_i;
            pend     <= 1'b1;
         end else if (frame) begin
            pend     <= 1'b0;
         end
      end
   end

   // Decoder feed, then panel drive one cycle later once seg_i has settled.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         nibble_o <= 4'd0;
         seg_o    <= 8'h00;
         an_o     <= {DIGITS{1'b0}};
      end else begin
         nibble_o <= disp_val[{idx, 2'b00} +: 4];
         if (lit) begin
            seg_o <= {seg_i[7:1], disp_dp[idx]};
            an_o  <= {{(DIGITS-1){1'b0}}, 1'b1} << idx;
         end else begin
            seg_o <= 8'h00;
            an_o  <= {DIGITS{1'b0}};
         end
      end
   end

endmodule

// File: tb/tb_panel_scan.sv
// Directed bench for panel_scan (4 digits, 16-clock slots, 2-clock guard) with a
// hex-to-segment decoder closing the nibble_o -> seg_i loop.
module tb_panel_scan;

   localparam int DIGITS    = 4;
   localparam int SLOT_BITS = 4;
   localparam int GUARD     = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] value;
   logic [3:0]  dp;
   logic        load;
   logic        ack;
   logic        blank_lz;
   logic [3:0]  bright;
   logic [3:0]  nibble;
   logic [7:0]  seg_in;
   logic [7:0]  seg_out;
   logic [3:0]  an;

   int checks = 0;
   int errors = 0;
   int k;

   panel_scan #(.DIGITS(DIGITS), .SLOT_BITS(SLOT_BITS), .GUARD(GUARD)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .value_i(value), .dp_i(dp), .load_i(load),
      .ack_o(ack), .blank_lz_i(blank_lz), .bright_i(bright), .nibble_o(nibble),
      .seg_i(seg_in), .seg_o(seg_out), .an_o(an)
   );

   always #5 clk = ~clk;

   // Decoder bit0 is driven high so that a DUT passing it through is caught.
   function automatic logic [7:0] hex_seg(input logic [3:0] n);
      logic [6:0] p;
      case (n)
         4'h0: p = 7'b1111110;  4'h1: p = 7'b0110000;
         4'h2: p = 7'b1101101;  4'h3: p = 7'b1111001;
         4'h4: p = 7'b0110011;  4'h5: p = 7'b1011011;
         4'h6: p = 7'b1011111;  4'h7: p = 7'b1110000;
         4'h8: p = 7'b1111111;  4'h9: p = 7'b1111011;
         4'hA: p = 7'b1110111;  4'hB: p = 7'b0011111;
         4'hC: p = 7'b1001110;  4'hD: p = 7'b0111101;
         4'hE: p = 7'b1001111;  4'hF: p = 7'b1000111;
         default: p = 7'b0000000;
      endcase
      return {p, 1'b1};
   endfunction

   always_comb seg_in = hex_seg(nibble);

   // Clock edges since reset release; frame m occupies k = 64m+1 .. 64m+64.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) k <= 0;
      else        k <= k + 1;
   end

   // Checks one whole frame cycle by cycle; optionally issues loads at cycles 10 and 30.
   task automatic scan_frame(input string name, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3, input logic [3:0] b,
                             input int nloads, input logic [15:0] va, input logic [15:0] vb,
                             input logic [3:0] ldp, input logic exp_ack);
      logic [7:0] es [4];
      logic [3:0] exp_an;
      logic [7:0] exp_seg;
      int d;
      int cc;
      int wait_n;
      es = '{e0, e1, e2, e3};
      wait_n = 0;
      while (k % 64 != 0) begin
         @(negedge clk);
         wait_n++;
         if (wait_n > 70) begin
            checks++; errors++;
            $display("FAIL %s frame_align: k=%0d never reached a frame boundary", name, k);
            return;
         end
      end
      for (int kk = 1; kk <= 64; kk++) begin
         @(negedge clk);
         d  = (kk - 1) / 16;
         cc = (kk - 1) % 16;
         exp_an  = (cc >= GUARD && cc <= int'(b) && es[d] != 8'h00) ? (4'b0001 << d) : 4'b0000;
         exp_seg = (exp_an != 4'b0000) ? es[d] : 8'h00;
         checks += 3;
         if (an !== exp_an) begin
            errors++;
            $display("FAIL %s an_o cycle %0d: got %b expected %b", name, kk, an, exp_an);
         end
         if (seg_out !== exp_seg) begin
            errors++;
            $display("FAIL %s seg_o cycle %0d: got %h expected %h", name, kk, seg_out, exp_seg);
         end
         if (ack !== ((kk == 64) ? exp_ack : 1'b0)) begin
            errors++;
            $display("FAIL %s ack_o cycle %0d: got %b expected %b", name, kk, ack,
                     (kk == 64) ? exp_ack : 1'b0);
         end
         if (kk == 10 && nloads >= 1) begin
            value = va; dp = ldp; load = 1'b1;
         end else if (kk == 30 && nloads >= 2) begin
            value = vb; dp = ldp; load = 1'b1;
         end else begin
            load = 1'b0;
         end
      end
   endtask

   task automatic check_reset_outputs(input string name);
      checks += 4;
      if (ack !== 1'b0)     begin errors++; $display("FAIL %s ack_o: got %b expected 0", name, ack); end
      if (an !== 4'b0000)   begin errors++; $display("FAIL %s an_o: got %b expected 0000", name, an); end
      if (seg_out !== 8'h00) begin errors++; $display("FAIL %s seg_o: got %h expected 00", name, seg_out); end
      if (nibble !== 4'h0)  begin errors++; $display("FAIL %s nibble_o: got %h expected 0", name, nibble); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; load = 1'b0; value = 16'h0000; dp = 4'h0;
      blank_lz = 1'b0; bright = 4'd15;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
   endtask

   task automatic test_idle_scan();
      scan_frame("idle0", 8'hFC, 8'hFC, 8'hFC, 8'hFC, 4'd15, 0, 16'h0, 16'h0, 4'h0, 1'b0);
      scan_frame("idle1", 8'hFC, 8'hFC, 8'hFC, 8'hFC, 4'd15, 0, 16'h0, 16'h0, 4'h0, 1'b0);
   endtask

   task automatic test_load();
      scan_frame("load_mid",  8'hFC, 8'hFC, 8'hFC, 8'hFC, 4'd15, 1, 16'h1234, 16'h0, 4'h0, 1'b1);
      scan_frame("show_1234", 8'h66, 8'hF2, 8'hDA, 8'h60, 4'd15, 0, 16'h0, 16'h0, 4'h0, 1'b0);
   endtask

   task automatic test_back_to_back();
      scan_frame("double_load", 8'h66, 8'hF2, 8'hDA, 8'h60, 4'd15, 2, 16'h1111, 16'h2222, 4'h0, 1'b1);
      scan_frame("show_2222",   8'hDA, 8'hDA, 8'hDA, 8'hDA, 4'd15, 0, 16'h0, 16'h0, 4'h0, 1'b0);
      scan_frame("keep_2222",   8'hDA, 8'hDA, 8'hDA, 8'hDA, 4'd15, 0, 16'h0, 16'h0, 4'h0, 1'b0);
   endtask

   task automatic test_blanking();
      scan_frame("load_0050", 8'hDA, 8'hDA, 8'hDA, 8'hDA, 4'd15, 1, 16'h0050, 16'h0, 4'h0, 1'b1);
      blank_lz = 1'b1;
      scan_frame("blank_0050", 8'hFC, 8'hB6, 8'h00, 8'h00, 4'd15, 1, 16'h0050, 16'h0, 4'b1000, 1'b1);
      scan_frame("dp3_lit",    8'hFC, 8'hB6, 8'h00, 8'hFD, 4'd15, 0, 16'h0, 16'h0, 4'h0, 1'b0);
   endtask

   task automatic test_brightness();
      bright = 4'd3;
      scan_frame("bright3", 8'hFC, 8'hB6, 8'h00, 8'hFD, 4'd3, 0, 16'h0, 16'h0, 4'h0, 1'b0);
      bright = 4'd0;
      scan_frame("bright0", 8'hFC, 8'hB6, 8'h00, 8'hFD, 4'd0, 0, 16'h0, 16'h0, 4'h0, 1'b0);
      bright = 4'd15;
      blank_lz = 1'b0;
   endtask

   task automatic test_reset_discard();
      repeat (10) @(negedge clk);
      value = 16'h5555; dp = 4'hF; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("midreset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      scan_frame("after_reset0", 8'hFC, 8'hFC, 8'hFC, 8'hFC, 4'd15, 0, 16'h0, 16'h0, 4'h0, 1'b0);
      scan_frame("after_reset1", 8'hFC, 8'hFC, 8'hFC, 8'hFC, 4'd15, 0, 16'h0, 16'h0, 4'h0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_idle_scan();
      test_load();
      test_back_to_back();
      test_blanking();
      test_brightness();
      test_reset_discard();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
